button_conditioner: RTL

Per-button synchronizer, debouncer and single-clock-enable pulse generator for the five board push-buttons (L, R, U, D, C). It sits between the raw FPGA pins and the game controller. The controller consumes exactly one cycle-wide enable per physical press, and this block produces that enable. Each bit runs an independent debounce state machine. An optional auto-repeat enable is available for cursor movement.

---
 rtl/button_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-flop synchronizer, debounce FSM and
// press-enable generator for the board push-buttons {L,R,U,D,C}.
// Optional auto-repeat on btn_mcen is enabled by defining BTN_AUTOREPEAT_EN;
// without it, btn_mcen is identical to btn_scen.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 12_500_000
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_scen,
  output logic [N_BTN-1:0] btn_mcen
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PWAIT = 3'd1,
    PULSE = 3'd2,
    HELD  = 3'd3,
    RWAIT = 3'd4
  } state_t;

  // Reject parameter sets the timing model cannot honour.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: invalid timing parameters");
  end

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync;

  // Two-stage synchronizer for the asynchronous pin levels.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync  <= sync1;
    end
  end

  for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_btn
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             db_q, scen_q, mcen_q;
    logic             db_nxt, scen_nxt, mcen_nxt;

    // Debounce next-state and next-output decode; outputs follow next state.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        IDLE: begin
          if (sync[gi]) begin
            state_nxt = PWAIT;
            cnt_nxt   = '0;
          end
        end
        PWAIT: begin
          if (!sync[gi])             state_nxt = IDLE;
          else if (cnt == CNT_LAST)  state_nxt = PULSE;
          else                       cnt_nxt   = cnt + CNT_W'(1);
        end
        PULSE: state_nxt = HELD;
        HELD: begin
          if (!sync[gi]) begin
            state_nxt = RWAIT;
            cnt_nxt   = '0;
          end
        end
        RWAIT: begin
          if (sync[gi])              state_nxt = HELD;
          else if (cnt == CNT_LAST)  state_nxt = IDLE;
          else                       cnt_nxt   = cnt + CNT_W'(1);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
      db_nxt   = (state_nxt == PULSE) || (state_nxt == HELD) || (state_nxt == RWAIT);
      scen_nxt = (state_nxt == PULSE);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rem, rem_nxt;

    // Cycles left until the next repeat pulse; only PULSE/HELD cycles count.
    always_comb begin
      rem_nxt = rem;
      if (state_nxt == IDLE || state_nxt == PWAIT || state_nxt == PULSE)
        rem_nxt = REP_W'(REPEAT_DELAY);
      else if (state == PULSE || state == HELD)
        rem_nxt = (rem == '0) ? REP_W'(REPEAT_PERIOD - 1) : rem - REP_W'(1);
      mcen_nxt = scen_nxt | ((state_nxt == HELD) && (rem_nxt == '0));
    end

    // Repeat countdown register.
    always_ff @(posedge Clk or posedge reset) begin
      if (reset) rem <= REP_W'(REPEAT_DELAY);
      else       rem <= rem_nxt;
    end
`else
    assign mcen_nxt = scen_nxt;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        db_q   <= 1'b0;
        scen_q <= 1'b0;
        mcen_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        db_q   <= db_nxt;
        scen_q <= scen_nxt;
        mcen_q <= mcen_nxt;
      end
    end

    assign btn_db[gi]   = db_q;
    assign btn_scen[gi] = scen_q;
    assign btn_mcen[gi] = mcen_q;
  end

endmodule
